am_audio_stage: RTL and testbench
=================================

# am_audio_stage

Converts the AM demodulator's 16-bit power stream (I²+Q²) into signed 16-bit audio samples for the audio output path. Per accepted sample:
- compute an 8-bit envelope magnitude as floor(sqrt(power)) with an iterative one-bit-per-cycle FSM;
- subtract a leaky-integrator DC estimate to remove the carrier level;
- present the result with a one-cycle valid strobe.

Sits directly downstream of the AM demodulator and upstream of the audio DAC/PWM stage.

## Interface
Parameters:
- DC_SHIFT, 8, DC integrator time constant as a power of two; legal range 4..12.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- power_in  in  16  unsigned I²+Q² from the demodulator.
- power_valid  in  1  one-cycle strobe qualifying power_in.
- audio_out  out  16  signed audio sample, two's complement.
- audio_valid  out  1  one-cycle strobe qualifying audio_out.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky flag: a power_valid arrived while busy; cleared only by rst.

## Operation
- States: IDLE, SQRT, FILT.
- IDLE:
  - On power_valid=1, latch power_in, clear root and remainder, set bit index to 7, and go to SQRT.
  - Otherwise stay in IDLE.
- SQRT: one result bit per cycle, bit 7 down to 0, for 8 cycles total. The final root is exactly floor(sqrt(power)), range 0..255. After bit 0, go to FILT. The restoring or non-restoring algorithm is an implementation choice, but no multiplier IP is used.
- FILT:
  - dc = dc_acc >> DC_SHIFT, using the value before this update.
  - audio_out <= sign-extended (mag − dc) << 7. Range is −32640..+32640, so no saturation is needed.
  - dc_acc <= dc_acc + mag − dc. dc_acc is unsigned, 9+DC_SHIFT bits wide, and never wraps.
  - audio_valid <= 1; go to IDLE.
- Steady state: a constant input mag gives dc = mag exactly, so audio_out = 0.
- power_valid when state ≠ IDLE: the sample is dropped, overrun <= 1, and the in-flight computation is unaffected.
- audio_out holds its value between strobes.

## Timing
- Reset values: audio_out=0, audio_valid=0, busy=0, overrun=0, dc_acc=0, state=IDLE.
- rst asserted at any time, including mid-SQRT or in FILT:
  - all registers return to reset values immediately;
  - the in-flight sample is discarded and produces no audio_valid.
- Sample accepted at edge N:
  - SQRT iterations occur at edges N+1..N+8;
  - FILT executes at edge N+9, so audio_valid is high for exactly the cycle after edge N+9;
  - latency is 9 clocks.
- busy is high from after edge N until edge N+9 inclusive. It is low after N+9.
- Minimum accepted input spacing is 10 clocks. A power_valid sampled at edge N+10 is accepted; one sampled at N+1..N+9 is an overrun.
- The upstream strobe is synchronous to clk; any clkData crossing is resolved upstream.

## Test plan
- Reset: hold rst, then release. All outputs are 0 and there is no audio_valid for 20 idle cycles.
- Sqrt accuracy, each input a single sample after reset so dc=0:
  - 0x0000 → audio_out=0;
  - 99 → 9<<7=1152;
  - 10000 → 12800;
  - 0xFFFF → 255<<7=32640;
  - each strobe arrives exactly 9 clocks after its input.
- Exhaustive sqrt: sweep power 0..65535 at spacing 10, with rst pulsed between samples. Each audio_out equals floor(sqrt(p))<<7.
- DC convergence, DC_SHIFT=8: feed 10000 at spacing 10 for 4096 samples. The first output is 12800, outputs decrease monotonically, and the final outputs are 0. Then feed 0 once → audio_out=−12800.
- Overrun: valid at N and N+5. There is exactly one audio_valid (after edge N+9) and overrun=1 from edge N+5 onward. Valid at N+10 is accepted normally, and overrun stays 1.
- Reset mid-operation: valid at N, rst pulse at N+4. No audio_valid appears, busy=0, overrun=0, dc_acc=0. A following sample of 10000 produces 12800.

Source files
------------

// File: rtl/am_audio_stage_if.sv
// Sample/audio handshake bundle between the AM demodulator, the audio
// stage and the downstream DAC/PWM path.
interface am_audio_stage_if;
  logic [15:0] power_in;     // unsigned I^2+Q^2 from the demodulator
  logic        power_valid;  // one-cycle strobe qualifying power_in
  logic [15:0] audio_out;    // signed audio sample, two's complement
  logic        audio_valid;  // one-cycle strobe qualifying audio_out
  logic        busy;         // stage is not idle
  logic        overrun;      // sticky: a sample arrived while busy

  // Upstream side: drives power samples, observes audio and status.
  modport master (
    output power_in, power_valid,
    input  audio_out, audio_valid, busy, overrun
  );

  // Audio stage side.
  modport slave (
    input  power_in, power_valid,
    output audio_out, audio_valid, busy, overrun
  );
endinterface

// File: rtl/am_audio_stage.sv
// AM audio stage: per accepted power sample, an 8-cycle restoring square
// root yields the envelope magnitude, a leaky integrator tracks the carrier
// level, and the difference is emitted as a signed audio sample.
module am_audio_stage #(
  parameter int DC_SHIFT = 8  // integrator time constant, 2**DC_SHIFT samples (4..12)
) (
  input  logic             clk,
  input  logic             rst,
  am_audio_stage_if.slave  bus
);

  localparam int ACC_W = 9 + DC_SHIFT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SQRT = 2'd1;
  localparam logic [1:0] S_FILT = 2'd2;

  logic [1:0]       r_state;
  logic [15:0]      r_rad;          // radicand, consumed two bits per step from the top
  logic [7:0]       r_root;         // partial root, final value is floor(sqrt(power))
  logic [8:0]       r_rem;          // remainder, never exceeds 2*root <= 510
  logic [2:0]       r_bit;          // root bit being resolved this cycle
  logic [ACC_W-1:0] r_dc_acc;       // DC estimate scaled by 2**DC_SHIFT
  logic [15:0]      r_audio;
  logic             r_audio_valid;
  logic             r_overrun;

  // Restoring square-root step: bring down the next radicand pair and try
  // subtracting (4*root + 1); success sets the new root bit.
  logic [10:0] w_rem_sh;
  logic [10:0] w_trial;
  logic        w_fit;
  logic [8:0]  w_rem_sub;

  assign w_rem_sh  = {r_rem, r_rad[15:14]};
  assign w_trial   = {1'b0, r_root, 2'b01};
  assign w_fit     = (w_rem_sh >= w_trial);
  assign w_rem_sub = 9'(w_rem_sh - w_trial);

  // Carrier removal: dc is at most 255 because the accumulator settles below
  // 256 << DC_SHIFT, so mag - dc always fits a 9-bit signed value.
  logic [8:0]       w_dc;
  logic [8:0]       w_diff;
  logic [ACC_W-1:0] w_acc_next;

  assign w_dc       = r_dc_acc[ACC_W-1:DC_SHIFT];
  assign w_diff     = {1'b0, r_root} - w_dc;
  assign w_acc_next = r_dc_acc + ACC_W'(r_root) - ACC_W'(w_dc);

  // Sample FSM: accept in IDLE, resolve one root bit per cycle, then filter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, not just the control state,
      // so an interrupted sample leaves nothing behind.
      r_state       <= S_IDLE;
      r_rad         <= '0;
      r_root        <= '0;
      r_rem         <= '0;
      r_bit         <= '0;
      r_dc_acc      <= '0;
      r_audio       <= '0;
      r_audio_valid <= 1'b0;
    end else begin
      r_audio_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.power_valid) begin
            r_rad   <= bus.power_in;
            r_root  <= '0;
            r_rem   <= '0;
            r_bit   <= 3'd7;
            r_state <= S_SQRT;
          end
        end
        S_SQRT: begin
          r_rad <= {r_rad[13:0], 2'b00};
          if (w_fit) begin
            r_rem  <= w_rem_sub;
            r_root <= {r_root[6:0], 1'b1};
          end else begin
            r_rem  <= w_rem_sh[8:0];
            r_root <= {r_root[6:0], 1'b0};
          end
          r_bit <= r_bit - 3'd1;
          if (r_bit == 3'd0) begin
            r_state <= S_FILT;
          end
        end
        S_FILT: begin
          r_audio       <= {w_diff, 7'b0};
          r_dc_acc      <= w_acc_next;
          r_audio_valid <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky overrun: any strobe that arrives while a sample is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (bus.power_valid && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.audio_out   = r_audio;
  assign bus.audio_valid = r_audio_valid;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_am_audio_stage.sv
// Directed bench for am_audio_stage: reset, sqrt accuracy and latency,
// DC convergence, overrun behaviour and reset during a computation.
module tb_am_audio_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  am_audio_stage_if bus ();

  am_audio_stage #(.DC_SHIFT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference integer square root by upward search.
  function automatic int isqrt(input int p);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= p) r++;
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge: strobe p for the next edge (edge N), then wait for
  // audio_valid. lat counts edges after N; busy must stay high until the strobe.
  task automatic issue_and_wait(input logic [15:0] p, output logic [15:0] out,
                                output int lat, output bit busy_ok);
    bus.power_in    = p;
    bus.power_valid = 1'b1;
    @(negedge clk);
    bus.power_valid = 1'b0;
    lat     = 0;
    busy_ok = (bus.busy === 1'b1) && (bus.audio_valid === 1'b0);
    while (bus.audio_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.audio_valid !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    out = bus.audio_out;
  endtask

  task automatic run_sample(input logic [15:0] p, output logic [15:0] out,
                            output int lat, output bit busy_ok);
    @(negedge clk);
    issue_and_wait(p, out, lat, busy_ok);
  endtask

  initial begin
    logic [15:0] out;
    logic [15:0] prev;
    logic [15:0] first;
    logic [15:0] val;
    logic [15:0] vec [12];
    int          lat;
    int          nv;
    int          pos;
    bit          busy_ok;
    bit          mono;
    bit          lat_ok;

    n_checks = 0;
    n_errors = 0;
    clk = 1'b0;
    rst = 1'b0;
    bus.power_in    = '0;
    bus.power_valid = 1'b0;

    // ---- reset ----
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_audio_out", bus.audio_out, 16'd0);
    check("rst_audio_valid", bus.audio_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.audio_valid !== 1'b0) nv++;
    end
    check("idle_no_valid", nv, 0);
    check("idle_audio_out", bus.audio_out, 16'd0);
    check("idle_busy", bus.busy, 1'b0);

    // ---- sqrt accuracy with hand-computed values, dc = 0 ----
    pulse_reset();
    run_sample(16'h0000, out, lat, busy_ok);
    check("sqrt_0", out, 16'd0);
    check("lat_0", lat, 9);
    check("busy_0", busy_ok, 1'b1);
    @(negedge clk);
    check("strobe_one_cycle", bus.audio_valid, 1'b0);

    pulse_reset();
    run_sample(16'd99, out, lat, busy_ok);
    check("sqrt_99", out, 16'd1152);
    check("lat_99", lat, 9);
    @(negedge clk);
    check("hold_99", bus.audio_out, 16'd1152);

    pulse_reset();
    run_sample(16'd10000, out, lat, busy_ok);
    check("sqrt_10000", out, 16'd12800);
    check("lat_10000", lat, 9);
    check("busy_10000", busy_ok, 1'b1);

    pulse_reset();
    run_sample(16'hFFFF, out, lat, busy_ok);
    check("sqrt_ffff", out, 16'd32640);
    check("lat_ffff", lat, 9);

    // ---- sampled sqrt sweep (boundaries plus random), dc = 0 ----
    vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd8, 16'd15, 16'd16,
            16'd255, 16'd256, 16'd65024, 16'd65025, 16'd12345};
    for (int i = 0; i < 12; i++) begin
      pulse_reset();
      run_sample(vec[i], out, lat, busy_ok);
      check($sformatf("sweep_%0d", vec[i]), out, 16'(isqrt(int'(vec[i])) << 7));
    end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] p;
      p = 16'($urandom_range(0, 65535));
      pulse_reset();
      run_sample(p, out, lat, busy_ok);
      check($sformatf("rand_%0d", p), out, 16'(isqrt(int'(p)) << 7));
    end

    // ---- DC convergence at the minimum spacing of 10 clocks ----
    pulse_reset();
    mono   = 1'b1;
    lat_ok = 1'b1;
    first  = '0;
    prev   = '0;
    @(negedge clk);
    for (int i = 0; i < 4096; i++) begin
      issue_and_wait(16'd10000, out, lat, busy_ok);
      if (i == 0) first = out;
      else if ($signed(out) > $signed(prev)) mono = 1'b0;
      if (lat != 9) lat_ok = 1'b0;
      prev = out;
    end
    check("dc_first", first, 16'd12800);
    check("dc_monotonic", mono, 1'b1);
    check("dc_latency", lat_ok, 1'b1);
    check("dc_final_zero", prev, 16'd0);
    check("dc_no_overrun", bus.overrun, 1'b0);
    issue_and_wait(16'd0, out, lat, busy_ok);
    check("dc_step_to_zero", out, 16'hCE00);

    // ---- overrun: valid at N, N+5, then N+10 ----
    pulse_reset();
    @(negedge clk);
    bus.power_in    = 16'd10000;
    bus.power_valid = 1'b1;
    @(negedge clk);
    bus.power_valid = 1'b0;
    nv  = 0;
    pos = 0;
    val = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus.power_valid = 1'b0;
      if (bus.audio_valid === 1'b1) begin
        nv++;
        pos = k;
        val = bus.audio_out;
      end
      if (k == 4) begin
        check("ovr_before", bus.overrun, 1'b0);
        bus.power_in    = 16'hFFFF;
        bus.power_valid = 1'b1;
      end
      if (k == 5) check("ovr_set", bus.overrun, 1'b1);
    end
    check("ovr_one_valid", nv, 1);
    check("ovr_valid_pos", pos, 9);
    check("ovr_inflight_value", val, 16'd12800);
    issue_and_wait(16'd10000, out, lat, busy_ok);
    check("ovr_next_accept", out, 16'd12800);
    check("ovr_next_lat", lat, 9);
    check("ovr_sticky", bus.overrun, 1'b1);

    // Charge the integrator so a missed dc_acc reset would show up later.
    run_sample(16'hFFFF, out, lat, busy_ok);
    check("charge_1", out, 16'd32640);
    run_sample(16'hFFFF, out, lat, busy_ok);
    check("charge_2", out, 16'd32512);

    // ---- reset in the middle of SQRT ----
    @(negedge clk);
    bus.power_in    = 16'd10000;
    bus.power_valid = 1'b1;
    @(negedge clk);
    bus.power_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_overrun", bus.overrun, 1'b0);
    check("mid_rst_valid", bus.audio_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.audio_valid !== 1'b0) nv++;
    end
    check("mid_rst_discard", nv, 0);
    run_sample(16'd10000, out, lat, busy_ok);
    check("mid_rst_dc_cleared", out, 16'd12800);
    check("mid_rst_lat", lat, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
